// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared state, mode and glyph definitions for the race stats formatter
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } race_state_e;

    localparam logic [1:0] MODE_TIME  = 2'd0;
    localparam logic [1:0] MODE_HITS  = 2'd1;
    localparam logic [1:0] MODE_MISS  = 2'd2;
    localparam logic [1:0] MODE_BLANK = 2'd3;

    localparam logic [3:0] GLYPH_MARK  = 4'd10;
    localparam logic [3:0] GLYPH_BLANK = 4'd12;

    // Blanks zero digits above the units digit, scanning down from digit ndig-1
    // until the first nonzero digit; digits at or above ndig pass through.
    function automatic logic [15:0] blank_lz(input logic [15:0] d, input int ndig);
        logic lead;
        blank_lz = d;
        lead     = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (i < ndig) begin
                if (lead && (d[i*4 +: 4] == 4'd0)) begin
                    blank_lz[i*4 +: 4] = GLYPH_BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// rtl/bcd_sat_counter.sv - multi-digit BCD up-counter that sticks at all-nines
module bcd_sat_counter #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [NDIG*4-1:0] q
);

    logic [NDIG*4-1:0] r_q;
    logic [NDIG*4-1:0] w_next;
    logic              w_all_nines;
    logic              w_carry;

    always_comb begin
        w_next      = r_q;
        w_carry     = 1'b1;
        w_all_nines = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (r_q[i*4 +: 4] != 4'd9) begin
                w_all_nines = 1'b0;
            end
            if (w_carry) begin
                if (r_q[i*4 +: 4] == 4'd9) begin
                    w_next[i*4 +: 4] = 4'd0;
                end else begin
                    w_next[i*4 +: 4] = r_q[i*4 +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && !w_all_nines) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/race_stats_formatter.sv
// rtl/race_stats_formatter.sv - typing-race timer/hit/miss counters with 4-glyph display output
module race_stats_formatter
    import race_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        finish,
    input  logic        hit,
    input  logic        miss,
    input  logic [1:0]  mode,
    output logic [15:0] nums,
    output logic        running,
    output logic        done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    race_state_e   r_state;
    race_state_e   w_state_next;
    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_done;
    logic [15:0]   r_nums;
    logic [15:0]   w_nums;
    logic          w_clr;
    logic          w_in_run;
    logic          w_wrap;
    logic [11:0]   w_sec;
    logic [15:0]   w_hits;
    logic [7:0]    w_miss;

    assign w_wrap = (r_presc == PRESC_MAX);

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_in_run     = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_clr        = 1'b1;
                end
            end
            ST_RUN: begin
                w_in_run = 1'b1;
                // The tick that lands seconds on 999 also ends the race.
                if (finish || (w_wrap && (w_sec == 12'h998))) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_nums    <= 16'hCCC0;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == ST_RUN);
            r_done    <= (w_state_next == ST_DONE);
            r_nums    <= w_nums;
            if (w_clr) begin
                r_presc <= '0;
            end else if (w_in_run) begin
                r_presc <= w_wrap ? '0 : r_presc + PW'(1);
            end
        end
    end

    bcd_sat_counter #(.NDIG(3)) u_sec (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_in_run && w_wrap),
        .q   (w_sec)
    );

    bcd_sat_counter #(.NDIG(4)) u_hits (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_in_run && hit),
        .q   (w_hits)
    );

    bcd_sat_counter #(.NDIG(2)) u_miss (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_in_run && miss),
        .q   (w_miss)
    );

    always_comb begin
        w_nums = {4{GLYPH_BLANK}};
        unique case (mode)
            MODE_TIME: begin
                w_nums          = blank_lz({4'd0, w_sec}, 3);
                w_nums[15:12]   = GLYPH_BLANK;
            end
            MODE_HITS: begin
                w_nums = blank_lz(w_hits, 4);
            end
            MODE_MISS: begin
                w_nums          = blank_lz({8'd0, w_miss}, 2);
                w_nums[15:12]   = GLYPH_MARK;
                w_nums[11:8]    = GLYPH_BLANK;
            end
            default: begin
                w_nums = {4{GLYPH_BLANK}};
            end
        endcase
    end

    assign nums    = r_nums;
    assign running = r_running;
    assign done    = r_done;

endmodule
